pack_metadata_mc: RTL

Multi-channel, double-buffered successor to the single-channel metadata packer in the USRP1 receive chain. It sits between the decimated sample stream and the RX FIFO. It hides a per-frame metadata record (trigger count, ACP/ARP, timestamp) in the unused high-order bits of the first words of each frame. A pending buffer lets host/trigger logic load the next record while the current one is still being emitted. A start-aligned frame state machine reports truncation and overrun.

---
 rtl/pack_metadata_mc.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pack_metadata_mc.sv
// pack_metadata_mc: hides a per-frame metadata record in the unused high bits
// of the first N sample words of each frame, for nchan channels in parallel.
// A pending buffer lets the next record be loaded while the current one is
// still being emitted. A start arriving mid-frame abandons the remaining words
// and pulses truncated. An init that overwrites an unconsumed record sets the
// sticky overrun flag.
module pack_metadata_mc #(
    parameter int data_width       = 16,
    parameter int data_width_used  = 12,
    parameter int meta_data_width  = 464,
    parameter int nchan            = 2,
    parameter bit fill_sign_extend = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          init,
    input  logic                          start,
    input  logic [meta_data_width-1:0]    meta_data,
    input  logic [nchan*data_width-1:0]   data_in,
    input  logic                          strobe_in,
    output logic [nchan*data_width-1:0]   data_out,
    output logic                          strobe_out,
    output logic                          busy,
    output logic                          meta_last,
    output logic                          truncated,
    output logic                          overrun
);

    localparam int U  = data_width_used;
    localparam int P  = data_width - data_width_used;
    localparam int B  = nchan * P;
    localparam int N  = (meta_data_width + B - 1) / B;
    localparam int CW = $clog2(N + 1);
    localparam int EW = N * B;
    localparam int DW = nchan * data_width;

    typedef enum logic {IDLE, PACK} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                count_q, count_d;
    logic [meta_data_width-1:0]   pending_q, pending_d;
    logic                         pending_valid_q, pending_valid_d;
    logic [meta_data_width-1:0]   active_q, active_d;
    logic                         overrun_q, overrun_d;
    logic                         truncated_d;
    logic                         meta_last_d;
    logic [DW-1:0]                word_d;

    // Effective frame context seen by this cycle's strobe (after any start bypass)
    state_t                       state_eff;
    logic [CW-1:0]                count_eff;
    logic [meta_data_width-1:0]   active_eff;
    logic [EW-1:0]                active_ext;
    logic                         accept;

    // Fill value for the P high bits of a word that carries no metadata
    function automatic logic [P-1:0] fill_bits(input logic [U-1:0] sample);
        if (fill_sign_extend)
            return {P{sample[U-1]}};
        else
            return '0;
    endfunction

    assign accept = enable && strobe_in;

    // Frame control: start/init handling, then word advance for an accepted strobe
    always_comb begin
        state_eff       = state_q;
        count_eff       = count_q;
        active_eff      = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        overrun_d       = overrun_q;
        truncated_d     = 1'b0;

        if (start) begin
            truncated_d = (state_q == PACK);
            count_eff   = '0;
            if (pending_valid_q) begin
                active_eff      = pending_q;
                pending_valid_d = 1'b0;
                state_eff       = PACK;
            end else if (init) begin
                // No record waiting: the record arriving now is used directly
                active_eff = meta_data;
                state_eff  = PACK;
            end else begin
                state_eff = IDLE;
            end
        end

        if (init && !(start && !pending_valid_q)) begin
            pending_d       = meta_data;
            pending_valid_d = 1'b1;
            if (pending_valid_q && !start)
                overrun_d = 1'b1;
        end

        active_d    = active_eff;
        state_d     = state_eff;
        count_d     = count_eff;
        meta_last_d = 1'b0;
        if (accept && state_eff == PACK) begin
            if (count_eff == CW'(N - 1)) begin
                meta_last_d = 1'b1;
                state_d     = IDLE;
                count_d     = '0;
            end else begin
                count_d = count_eff + 1'b1;
            end
        end
    end

    // Output word: metadata slice in PACK, fill otherwise; low bits pass through
    always_comb begin
        active_ext = '0;
        active_ext[meta_data_width-1:0] = active_eff;
        word_d = '0;
        for (int c = 0; c < nchan; c++) begin
            if (state_eff == PACK)
                word_d[c*data_width + U +: P] = active_ext[(int'(count_eff) * nchan + c) * P +: P];
            else
                word_d[c*data_width + U +: P] = fill_bits(data_in[c*data_width +: U]);
            word_d[c*data_width +: U] = data_in[c*data_width +: U];
        end
    end

    // State, control flags and the output register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            count_q         <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
            overrun_q       <= 1'b0;
            truncated       <= 1'b0;
            meta_last       <= 1'b0;
            strobe_out      <= 1'b0;
            data_out        <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
            overrun_q       <= overrun_d;
            truncated       <= truncated_d;
            meta_last       <= meta_last_d;
            strobe_out      <= accept;
            if (accept)
                data_out <= word_d;
        end
    end

    // Pending record storage; only meaningful while pending_valid_q is set
    always_ff @(posedge clock) begin
        pending_q <= pending_d;
    end

    assign busy    = (state_q == PACK);
    assign overrun = overrun_q;

endmodule
